// File: rtl/alu_arb_pkg.sv
// Shared types and default parameters for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;
  localparam int ALU_LAT = 2;

  // Latency counter width, large enough for the full 1..15 latency range.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: grant, issue, wait out
// the ALU latency, then strobe the result back to the owner.
module alu_arbiter #(
  parameter int DATA_W  = alu_arb_pkg::DATA_W,
  parameter int OP_W    = alu_arb_pkg::OP_W,
  parameter int ALU_LAT = alu_arb_pkg::ALU_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [2*DATA_W-1:0] a_in,
  input  logic [2*DATA_W-1:0] b_in,
  input  logic [2*OP_W-1:0]   op_in,
  output logic [1:0]          gnt,
  output logic [1:0]          rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                busy,
  output logic                alu_start,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_opcode,
  input  logic [2*DATA_W-1:0] alu_out
);

  import alu_arb_pkg::*;

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             owner;
  logic [1:0]       win;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_gnt),
    .win  (win)
  );

  // Grant is combinational in IDLE and forced low while reset is held.
  assign gnt = (rst_n && (state == IDLE)) ? win : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_gnt   <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
    end else begin
      alu_start <= 1'b0;
      rsp_valid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner      <= win[1];
            last_gnt   <= win[1];
            alu_a      <= win[1] ? a_in[2*DATA_W-1:DATA_W] : a_in[DATA_W-1:0];
            alu_b      <= win[1] ? b_in[2*DATA_W-1:DATA_W] : b_in[DATA_W-1:0];
            alu_opcode <= win[1] ? op_in[2*OP_W-1:OP_W]    : op_in[OP_W-1:0];
            alu_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(ALU_LAT - 1);
          state <= WAIT;
        end
        // The ALU result is valid in the cycle where the count reaches zero.
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= alu_out;
            rsp_valid <= idx_to_onehot(owner);
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three builds (ALU_LAT 2, 1, 15), each with a small
// behavioural ALU, checked by directed scenarios and a timeline model.
module tb_alu_arbiter;

  localparam int DW = 8;
  localparam int OW = 3;
  localparam int RW = 2 * DW;
  localparam int NI = 3;
  localparam int LATS [NI] = '{2, 1, 15};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req        [NI];
  logic [RW-1:0]   a_in       [NI];
  logic [RW-1:0]   b_in       [NI];
  logic [2*OW-1:0] op_in      [NI];
  logic [1:0]      gnt        [NI];
  logic [1:0]      rsp_valid  [NI];
  logic [RW-1:0]   rsp_data   [NI];
  logic            busy       [NI];
  logic            alu_start  [NI];
  logic [DW-1:0]   alu_a      [NI];
  logic [DW-1:0]   alu_b      [NI];
  logic [OW-1:0]   alu_opcode [NI];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      3'd0:    return RW'(a) + RW'(b);
      3'd1:    return RW'(a) * RW'(b);
      default: return {a, b};
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return LATS[d];
  endfunction

  // The ALU drives its result only in the cycle ALU_LAT after the start pulse.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [RW-1:0] alu_out;
    logic [RW-1:0] res_q = '0;
    int            age = 0;

    always @(posedge clk) begin
      if (alu_start[g]) begin
        res_q <= alu_fn(alu_a[g], alu_b[g], alu_opcode[g]);
        age   <= 1;
      end else if (age != 0 && age < 64) begin
        age <= age + 1;
      end
    end

    assign alu_out = (age == LATS[g]) ? res_q : ~res_q;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(LATS[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req[g]),
      .a_in       (a_in[g]),
      .b_in       (b_in[g]),
      .op_in      (op_in[g]),
      .gnt        (gnt[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_data   (rsp_data[g]),
      .busy       (busy[g]),
      .alu_start  (alu_start[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_opcode (alu_opcode[g]),
      .alu_out    (alu_out)
    );
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int d, input int i, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OW-1:0] op);
    a_in[d][i*DW +: DW]  = a;
    b_in[d][i*DW +: DW]  = b;
    op_in[d][i*OW +: OW] = op;
  endtask

  // Leaves the clock at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < NI; d++) begin
      req[d]   = 2'b00;
      a_in[d]  = '0;
      b_in[d]  = '0;
      op_in[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NI; d++) begin
      req[d]   = 2'b11;
      a_in[d]  = RW'($urandom);
      b_in[d]  = RW'($urandom);
      op_in[d] = (2*OW)'($urandom);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      total++; if (gnt[d] !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt[%0d]: got=%b expected=00", d, gnt[d]); end
      total++; if (rsp_valid[d] !== 2'b00) begin bad++; $display("[TB] FAIL reset_rsp_valid[%0d]: got=%b expected=00", d, rsp_valid[d]); end
      total++; if (rsp_data[d] !== '0) begin bad++; $display("[TB] FAIL reset_rsp_data[%0d]: got=%h expected=0", d, rsp_data[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy[%0d]: got=%b expected=0", d, busy[d]); end
      total++; if (alu_start[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_alu_start[%0d]: got=%b expected=0", d, alu_start[d]); end
      total++; if ({alu_a[d], alu_b[d], alu_opcode[d]} !== '0) begin bad++; $display("[TB] FAIL reset_alu_ops[%0d]: got=%h/%h/%h expected=0/0/0", d, alu_a[d], alu_b[d], alu_opcode[d]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    req[0] = 2'b01;
    set_ops(0, 0, 8'd5, 8'd7, 3'd0);
    set_ops(0, 1, 8'd99, 8'd1, 3'd1);
    for (int k = 0; k <= 5; k++) begin
      if (k == 1) req[0] = 2'b00;
      #1;
      total++; if (gnt[0] !== ((k == 0) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL single_gnt k=%0d: got=%b expected=%b", k, gnt[0], (k == 0) ? 2'b01 : 2'b00); end
      total++; if (alu_start[0] !== (k == 1)) begin bad++; $display("[TB] FAIL single_alu_start k=%0d: got=%b expected=%b", k, alu_start[0], k == 1); end
      total++; if (busy[0] !== (k >= 1 && k <= 4)) begin bad++; $display("[TB] FAIL single_busy k=%0d: got=%b expected=%b", k, busy[0], k >= 1 && k <= 4); end
      total++; if (rsp_valid[0] !== ((k == 4) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL single_rsp_valid k=%0d: got=%b expected=%b", k, rsp_valid[0], (k == 4) ? 2'b01 : 2'b00); end
      if (k >= 1) begin
        total++; if ({alu_a[0], alu_b[0], alu_opcode[0]} !== {8'd5, 8'd7, 3'd0}) begin bad++; $display("[TB] FAIL single_alu_ops k=%0d: got=%0d/%0d/%0d expected=5/7/0", k, alu_a[0], alu_b[0], alu_opcode[0]); end
      end
      if (k >= 4) begin
        total++; if (rsp_data[0] !== 16'd12) begin bad++; $display("[TB] FAIL single_rsp_data k=%0d: got=%0d expected=12", k, rsp_data[0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_tie_from_reset();
    do_reset();
    req[0] = 2'b11;
    set_ops(0, 0, 8'd3, 8'd4, 3'd1);
    set_ops(0, 1, 8'd10, 8'd20, 3'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k == 1) req[0] = 2'b10;
      if (k == 6) req[0] = 2'b00;
      #1;
      total++; if (gnt[0] !== ((k == 0) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL tie_gnt k=%0d: got=%b", k, gnt[0]); end
      total++; if (rsp_valid[0] !== ((k == 4) ? 2'b01 : (k == 9) ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL tie_rsp_valid k=%0d: got=%b", k, rsp_valid[0]); end
      if (k == 4) begin
        total++; if (rsp_data[0] !== 16'd12) begin bad++; $display("[TB] FAIL tie_rsp_data0: got=%0d expected=12", rsp_data[0]); end
      end
      if (k == 9) begin
        total++; if (rsp_data[0] !== 16'd30) begin bad++; $display("[TB] FAIL tie_rsp_data1: got=%0d expected=30", rsp_data[0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_res;
    int            w;
    exp_res = '0;
    do_reset();
    req[0] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      a_in[0]  = RW'($urandom);
      b_in[0]  = RW'($urandom);
      op_in[0] = (2*OW)'($urandom);
      #1;
      w = (k / 5) % 2;
      total++; if (gnt[0] !== ((k % 5 == 0) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00)) begin bad++; $display("[TB] FAIL b2b_gnt k=%0d: got=%b", k, gnt[0]); end
      total++; if (busy[0] !== (k % 5 != 0)) begin bad++; $display("[TB] FAIL b2b_busy k=%0d: got=%b expected=%b", k, busy[0], k % 5 != 0); end
      if (k % 5 == 0) exp_res = alu_fn(a_in[0][w*DW +: DW], b_in[0][w*DW +: DW], op_in[0][w*OW +: OW]);
      if (k % 5 == 4) begin
        total++; if (rsp_valid[0] !== ((w == 1) ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL b2b_rsp_valid k=%0d: got=%b", k, rsp_valid[0]); end
        total++; if (rsp_data[0] !== exp_res) begin bad++; $display("[TB] FAIL b2b_rsp_data k=%0d: got=%h expected=%h", k, rsp_data[0], exp_res); end
      end
      next_cycle();
    end
  endtask

  task automatic test_pending();
    do_reset();
    req[0] = 2'b01;
    set_ops(0, 0, 8'd1, 8'd1, 3'd0);
    set_ops(0, 1, 8'd77, 8'd3, 3'd1);
    for (int k = 0; k <= 5; k++) begin
      if (k == 1) req[0] = 2'b00;
      if (k == 2) req[0] = 2'b10;
      #1;
      total++; if (gnt[0] !== ((k == 0) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00)) begin bad++; $display("[TB] FAIL pending_gnt k=%0d: got=%b", k, gnt[0]); end
      if (k >= 1 && k <= 4) begin
        total++; if (alu_a[0] !== 8'd1) begin bad++; $display("[TB] FAIL pending_no_capture k=%0d: got=%0d expected=1", k, alu_a[0]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[0] = 2'b01;
    set_ops(0, 0, 8'd9, 8'd2, 3'd0);
    #1;
    total++; if (gnt[0] !== 2'b01) begin bad++; $display("[TB] FAIL rstmid_first_gnt: got=%b expected=01", gnt[0]); end
    next_cycle();
    req[0] = 2'b00;
    next_cycle();
    rst_n = 1'b0;
    #1;
    total++; if ({gnt[0], rsp_valid[0], busy[0], alu_start[0]} !== 6'b0) begin bad++; $display("[TB] FAIL rstmid_ctrl_zero: got gnt=%b rsp_valid=%b busy=%b alu_start=%b expected=0", gnt[0], rsp_valid[0], busy[0], alu_start[0]); end
    total++; if ({rsp_data[0], alu_a[0], alu_b[0], alu_opcode[0]} !== '0) begin bad++; $display("[TB] FAIL rstmid_data_zero: got=%h/%h/%h/%h expected=0", rsp_data[0], alu_a[0], alu_b[0], alu_opcode[0]); end
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if ({rsp_valid[0], alu_start[0], busy[0]} !== 4'b0) begin bad++; $display("[TB] FAIL rstmid_quiet k=%0d: got rsp_valid=%b alu_start=%b busy=%b expected=0", k, rsp_valid[0], alu_start[0], busy[0]); end
      total++; if (rsp_data[0] !== '0) begin bad++; $display("[TB] FAIL rstmid_rsp_data k=%0d: got=%h expected=0", k, rsp_data[0]); end
      next_cycle();
    end
    req[0] = 2'b11;
    #1;
    total++; if (gnt[0] !== 2'b01) begin bad++; $display("[TB] FAIL rstmid_tie_gnt: got=%b expected=01", gnt[0]); end
  endtask

  task automatic test_latency_builds();
    int L;
    for (int d = 1; d < NI; d++) begin
      L = lat_of(d);
      do_reset();
      req[d] = 2'b01;
      set_ops(d, 0, 8'd255, 8'd255, 3'd1);
      for (int k = 0; k <= L + 3; k++) begin
        if (k == 1) req[d] = 2'b00;
        #1;
        total++; if (gnt[d] !== ((k == 0) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL lat%0d_gnt k=%0d: got=%b", L, k, gnt[d]); end
        total++; if (alu_start[d] !== (k == 1)) begin bad++; $display("[TB] FAIL lat%0d_alu_start k=%0d: got=%b", L, k, alu_start[d]); end
        total++; if (busy[d] !== (k >= 1 && k <= L + 2)) begin bad++; $display("[TB] FAIL lat%0d_busy k=%0d: got=%b", L, k, busy[d]); end
        total++; if (rsp_valid[d] !== ((k == L + 2) ? 2'b01 : 2'b00)) begin bad++; $display("[TB] FAIL lat%0d_rsp_valid k=%0d: got=%b", L, k, rsp_valid[d]); end
        if (k == L + 2) begin
          total++; if (rsp_data[d] !== 16'd65025) begin bad++; $display("[TB] FAIL lat%0d_rsp_data: got=%0d expected=65025", L, rsp_data[d]); end
        end
        next_cycle();
      end
    end
  endtask

  // Model: a grant at cycle G fixes start at G+1, response at G+2+L and the
  // next possible grant at G+3+L.
  task automatic test_random(input int d, input int ncyc);
    int            L;
    int            gcyc;
    int            w;
    int            owner_m;
    int            last_m;
    logic          granted [2];
    logic          free;
    logic [1:0]    eg;
    logic [1:0]    ev;
    logic [RW-1:0] ed;
    logic [RW-1:0] eres;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [OW-1:0] eo;
    L = lat_of(d);
    gcyc = -1000; w = 0; owner_m = 0; last_m = 1;
    granted[0] = 1'b0; granted[1] = 1'b0;
    ed = '0; eres = '0; ea = '0; eb = '0; eo = '0;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (granted[i] || !req[d][i]) begin
          req[d][i] = ($urandom_range(0, 2) == 0);
          set_ops(d, i, DW'($urandom), DW'($urandom), OW'($urandom_range(0, 3)));
        end else if ($urandom_range(0, 15) == 0) begin
          req[d][i] = 1'b0;
        end
        granted[i] = 1'b0;
      end
      #1;
      free = (cyc >= gcyc + 3 + L);
      eg = 2'b00;
      if (free && req[d] != 2'b00) begin
        if (req[d] == 2'b01) w = 0;
        else if (req[d] == 2'b10) w = 1;
        else w = 1 - last_m;
        eg = (w == 1) ? 2'b10 : 2'b01;
      end
      ev = (cyc == gcyc + 2 + L) ? ((owner_m == 1) ? 2'b10 : 2'b01) : 2'b00;
      if (cyc == gcyc + 2 + L) ed = eres;
      total++; if (gnt[d] !== eg) begin bad++; $display("[TB] FAIL rnd%0d_gnt cyc=%0d: got=%b expected=%b", d, cyc, gnt[d], eg); end
      total++; if (busy[d] !== !free) begin bad++; $display("[TB] FAIL rnd%0d_busy cyc=%0d: got=%b expected=%b", d, cyc, busy[d], !free); end
      total++; if (alu_start[d] !== (cyc == gcyc + 1)) begin bad++; $display("[TB] FAIL rnd%0d_alu_start cyc=%0d: got=%b expected=%b", d, cyc, alu_start[d], cyc == gcyc + 1); end
      total++; if (rsp_valid[d] !== ev) begin bad++; $display("[TB] FAIL rnd%0d_rsp_valid cyc=%0d: got=%b expected=%b", d, cyc, rsp_valid[d], ev); end
      total++; if (rsp_data[d] !== ed) begin bad++; $display("[TB] FAIL rnd%0d_rsp_data cyc=%0d: got=%h expected=%h", d, cyc, rsp_data[d], ed); end
      total++; if ({alu_a[d], alu_b[d], alu_opcode[d]} !== {ea, eb, eo}) begin bad++; $display("[TB] FAIL rnd%0d_alu_ops cyc=%0d: got=%h/%h/%h expected=%h/%h/%h", d, cyc, alu_a[d], alu_b[d], alu_opcode[d], ea, eb, eo); end
      if (eg != 2'b00) begin
        gcyc       = cyc;
        owner_m    = w;
        last_m     = w;
        granted[w] = 1'b1;
        ea   = a_in[d][w*DW +: DW];
        eb   = b_in[d][w*DW +: DW];
        eo   = op_in[d][w*OW +: OW];
        eres = alu_fn(ea, eb, eo);
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int d = 0; d < NI; d++) begin
      req[d]   = 2'b00;
      a_in[d]  = '0;
      b_in[d]  = '0;
      op_in[d] = '0;
    end
    test_reset();
    test_single();
    test_tie_from_reset();
    test_back_to_back();
    test_pending();
    test_reset_mid();
    test_latency_builds();
    test_random(0, 300);
    test_random(1, 200);
    test_random(2, 400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, ALU operand width.
REQ-002 Parameter OP_W, default 3, ALU opcode width.
REQ-003 Parameter ALU_LAT, default 2, cycles from alu_start to valid alu_out; legal range 1..15.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  2  per-requester operation request, held high until granted.
REQ-008 a_in  in  2*DATA_W  packed operand A, requester i at slice i.
REQ-009 b_in  in  2*DATA_W  packed operand B.
REQ-010 op_in  in  2*OP_W  packed opcode.
REQ-011 gnt  out  2  one-hot grant, operands captured in the same cycle.
REQ-012 rsp_valid  out  2  one-hot one-cycle result strobe to the owning requester.
REQ-013 rsp_data  out  2*DATA_W  result, shared by both requesters.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.
REQ-015 alu_start  out  1  one-cycle start pulse to the ALU op_start.
REQ-016 alu_a, alu_b  out  DATA_W  registered ALU operands.
REQ-017 alu_opcode  out  OP_W  registered ALU opcode.
REQ-018 alu_out  in  2*DATA_W  ALU result.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE, req!=0: gnt[w] high combinationally for that cycle; operands of w captured at the edge; record owner=w; go to ISSUE.
REQ-021 Arbitration: a single requester always wins; on a tie the requester other than last_gnt wins; last_gnt updates only on a grant.
REQ-022 ISSUE: alu_start=1 for exactly one cycle; cnt loaded with ALU_LAT-1; go to WAIT.
REQ-023 WAIT: cnt decrements each cycle; at cnt==0, alu_out is captured into rsp_data at that edge; go to RESP.
REQ-024 RESP: rsp_valid[owner]=1 for one cycle; go to IDLE.
REQ-025 Timing: gnt in cycle T, alu_start T+1, alu_out sampled T+1+ALU_LAT, rsp_valid T+2+ALU_LAT; the earliest next gnt is T+3+ALU_LAT.
REQ-026 alu_a/alu_b/alu_opcode SHALL hold stable from ISSUE through RESP and retain the last values while IDLE.
REQ-027 rsp_data SHALL hold its value until the next capture.
REQ-028 req while busy: no gnt, no capture; the request stays pending.
REQ-029 A requester that drops req before grant loses its slot with no side effects.

Reset
REQ-030 rst_n low at any time: state=IDLE, cnt=0, last_gnt=1 (requester 0 wins the first tie), owner=0.
REQ-031 During reset, all outputs SHALL be zero.
REQ-032 Reset mid-operation discards the operation: no rsp_valid is issued, and no alu_start follows reset release without a new grant.

Structure
REQ-033 Package alu_arb_pkg SHALL hold the state enum type (arb_state_t) and parameter defaults DATA_W, OP_W, ALU_LAT.
REQ-034 The round-robin choice SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output one-hot win[1:0]), purely combinational.

Verification (bench ALU model: opcode 0 = A+B, 1 = A*B, latency ALU_LAT=2)
REQ-035 Only req0: a=8'd5, b=8'd7, op=0 at T -> gnt=01 at T; alu_start T+1; rsp_valid=01, rsp_data=16'd12 at T+4.
REQ-036 Both req from reset: req0 a=3,b=4,op=1; req1 a=10,b=20,op=0 -> req0 served first (rsp_data 12); req1 gnt at T+5, rsp_data 30 with rsp_valid=10.
REQ-037 Both held continuously -> grants alternate 0,1,0,1 at 5-cycle spacing; busy is low only in the grant cycles.
REQ-038 req1 raised during a req0 operation -> no gnt while busy; gnt=10 in the first IDLE cycle.
REQ-039 rst_n asserted in WAIT -> outputs zero immediately; no rsp_valid after release; the next tie grants requester 0.
REQ-040 ALU_LAT=1 and ALU_LAT=15 builds: rsp_valid at exactly T+2+ALU_LAT; a=255, b=255, op=1 -> rsp_data=16'd65025.
